// File: rtl/sysid_check_ctrl.sv
// Boot-time system-ID checker: reads the sysid slave over Avalon-MM and raises sticky pass/fail.
// Define SYSID_CHECK_TS_EN to also read and compare the timestamp word at address 1.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1413589754,
    parameter int unsigned START_DELAY    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    input  logic        recheck,
    output logic        busy,
    output logic        sysid_ok,
    output logic        sysid_fail,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [2:0]  attempts
);

    localparam logic [7:0]  DelayLast  = 8'(START_DELAY - 1);
    localparam logic [15:0] TmoLast    = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RetryLimit = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StDelay,
        StRdId,
        StWaitId,
        StRdTs,
        StWaitTs,
        StCheck,
        StPass,
        StFail
    } state_e;

    state_e      state_q;
    logic [7:0]  delay_cnt_q;
    logic [15:0] tmo_cnt_q;
    logic [3:0]  attempt_cnt_q;
    logic        tmo_hit;
    logic        phase_timeout;
    logic        words_match;
    state_e      after_id;

    assign attempts = attempt_cnt_q[2:0];
    assign tmo_hit  = (tmo_cnt_q >= TmoLast);

`ifdef SYSID_CHECK_TS_EN
    assign after_id    = StRdTs;
    assign words_match = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
`else
    logic unused_ts_param;
    assign unused_ts_param = ^EXPECTED_TS;
    assign after_id        = StCheck;
    assign words_match     = (id_value == EXPECTED_ID);
    assign ts_value        = '0;
`endif

    // Arriving read data or command acceptance always beats an expiring timeout.
    always_comb begin
        phase_timeout = 1'b0;
        unique case (state_q)
            StRdId, StRdTs:     phase_timeout = tmo_hit && avm_read && avm_waitrequest;
            StWaitId, StWaitTs: phase_timeout = tmo_hit && !avm_readdatavalid;
            default:            phase_timeout = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StDelay;
            delay_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            attempt_cnt_q <= '0;
            avm_read      <= 1'b0;
            avm_address   <= 1'b0;
            busy          <= 1'b1;
            sysid_ok      <= 1'b0;
            sysid_fail    <= 1'b0;
            timeout_err   <= 1'b0;
            id_value      <= '0;
`ifdef SYSID_CHECK_TS_EN
            ts_value      <= '0;
`endif
        end else if (phase_timeout) begin
            avm_read <= 1'b0;
            if (attempt_cnt_q <= RetryLimit) begin
                state_q     <= StDelay;
                delay_cnt_q <= '0;
            end else begin
                state_q     <= StFail;
                sysid_fail  <= 1'b1;
                timeout_err <= 1'b1;
                busy        <= 1'b0;
            end
        end else begin
            unique case (state_q)
                StDelay: begin
                    if (delay_cnt_q == DelayLast) begin
                        delay_cnt_q   <= '0;
                        attempt_cnt_q <= attempt_cnt_q + 4'd1;
                        avm_read      <= 1'b1;
                        avm_address   <= 1'b0;
                        tmo_cnt_q     <= '0;
                        state_q       <= StRdId;
                    end else begin
                        delay_cnt_q <= delay_cnt_q + 8'd1;
                    end
                end
                StRdId: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdatavalid) begin
                            id_value <= avm_readdata;
                            state_q  <= after_id;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 16'd1;
                            state_q   <= StWaitId;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                StWaitId: begin
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        state_q  <= after_id;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
`ifdef SYSID_CHECK_TS_EN
                StRdTs: begin
                    // Read is low for one cycle between the two commands; issue here.
                    if (!avm_read) begin
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        tmo_cnt_q   <= '0;
                    end else if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        if (avm_readdatavalid) begin
                            ts_value <= avm_readdata;
                            state_q  <= StCheck;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 16'd1;
                            state_q   <= StWaitTs;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                StWaitTs: begin
                    if (avm_readdatavalid) begin
                        ts_value <= avm_readdata;
                        state_q  <= StCheck;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
`endif
                StCheck: begin
                    busy <= 1'b0;
                    if (words_match) begin
                        sysid_ok <= 1'b1;
                        state_q  <= StPass;
                    end else begin
                        sysid_fail <= 1'b1;
                        state_q    <= StFail;
                    end
                end
                StPass, StFail: begin
                    if (recheck) begin
                        sysid_ok      <= 1'b0;
                        sysid_fail    <= 1'b0;
                        timeout_err   <= 1'b0;
                        attempt_cnt_q <= '0;
                        delay_cnt_q   <= '0;
                        busy          <= 1'b1;
                        state_q       <= StDelay;
                    end
                end
                default: state_q <= StDelay;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl with a small Avalon-MM sysid slave model.
// Expectations follow the SYSID_CHECK_TS_EN setting of the build.
module tb_sysid_check_ctrl;

    localparam int unsigned SDELAY = 16;
    localparam logic [31:0] EXP_TS = 32'd1413589754;
`ifdef SYSID_CHECK_TS_EN
    localparam int LAT = SDELAY + 4;
    localparam int NRD = 2;
    localparam int TSEN = 1;
    localparam logic LAST_ADDR = 1'b1;
`else
    localparam int LAT = SDELAY + 2;
    localparam int NRD = 1;
    localparam int TSEN = 0;
    localparam logic LAST_ADDR = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        recheck;
    logic        busy;
    logic        sysid_ok;
    logic        sysid_fail;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic [2:0]  attempts;

    int n_checks = 0;
    int n_errors = 0;

    // Slave configuration and monitor counters
    int          stall_cycles = 0;
    bit          respond = 1'b1;
    bit          spurious = 1'b0;
    logic [31:0] id_word = '0;
    logic [31:0] ts_word = EXP_TS;
    int          stall_left = 0;
    bit          loaded = 1'b0;
    int          acc_cnt = 0;
    int          stall_mon = 0;
    int          stab_err = 0;
    int          both_err = 0;
    bit          addr1_seen = 1'b0;
    bit          prev_stall = 1'b0;
    logic        prev_addr = 1'b0;

    sysid_check_ctrl #(
        .EXPECTED_ID    (32'd0),
        .EXPECTED_TS    (EXP_TS),
        .START_DELAY    (SDELAY),
        .TIMEOUT_CYCLES (10),
        .MAX_RETRIES    (3)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .recheck           (recheck),
        .busy              (busy),
        .sysid_ok          (sysid_ok),
        .sysid_fail        (sysid_fail),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value),
        .attempts          (attempts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave responds on the falling edge so its outputs are stable at the next rising edge.
    always @(negedge clock) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        if (!reset_n) begin
            loaded     = 1'b0;
            acc_cnt    = 0;
            stall_mon  = 0;
            stab_err   = 0;
            both_err   = 0;
            addr1_seen = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!avm_read || avm_address != prev_addr)) stab_err++;
            if (avm_read) begin
                if (!loaded) begin
                    loaded     = 1'b1;
                    stall_left = stall_cycles;
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                    stall_mon++;
                end else begin
                    loaded = 1'b0;
                    acc_cnt++;
                    avm_readdatavalid = respond;
                    avm_readdata      = avm_address ? ts_word : id_word;
                end
                if (avm_address) addr1_seen = 1'b1;
            end else begin
                loaded = 1'b0;
                if (spurious) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = 32'hdeadbeef;
                end
            end
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            if (sysid_ok && sysid_fail) both_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Counts rising edges until a verdict appears; -1 if the budget expires.
    task automatic wait_done(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clock);
            #1;
            if (sysid_ok || sysid_fail) begin
                edges = i;
                break;
            end
        end
        @(negedge clock);
    endtask

    int  edges;
    bit  found;

    initial begin
        reset_n = 1'b0;
        recheck = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_eq("rst_read", avm_read, 0);
        check_eq("rst_addr", avm_address, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_ok", sysid_ok, 0);
        check_eq("rst_fail", sysid_fail, 0);
        check_eq("rst_tmo", timeout_err, 0);
        check_eq("rst_id", id_value, 0);
        check_eq("rst_ts", ts_value, 0);
        check_eq("rst_att", attempts, 0);

        // Zero-wait, same-cycle-valid slave with matching words
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(200, edges);
        check_eq("pass_latency", edges, LAT);
        check_eq("pass_ok", sysid_ok, 1);
        check_eq("pass_att", attempts, 1);
        check_eq("pass_busy", busy, 0);
        check_eq("pass_ts", ts_value, TSEN ? EXP_TS : 32'd0);
        check_eq("pass_reads", acc_cnt, NRD);
        check_eq("pass_addr1", addr1_seen, TSEN);

        // Stray readdatavalid in PASS must not be captured
        spurious = 1'b1;
        repeat (3) @(negedge clock);
        spurious = 1'b0;
        @(negedge clock);
        check_eq("stray_id", id_value, 0);
        check_eq("stray_ok", sysid_ok, 1);

        // Timestamp off by one
        ts_word = EXP_TS + 32'd1;
        apply_reset();
        wait_done(200, edges);
        check_eq("mis_fail", sysid_fail, TSEN);
        check_eq("mis_ok", sysid_ok, 1 - TSEN);
        check_eq("mis_tmo", timeout_err, 0);
        check_eq("mis_ts", ts_value, TSEN ? EXP_TS + 32'd1 : 32'd0);
        check_eq("mis_att", attempts, 1);
        repeat (5) @(negedge clock);
        check_eq("mis_reads", acc_cnt, NRD);
        ts_word = EXP_TS;

        // Five-cycle waitrequest stall on every command
        stall_cycles = 5;
        apply_reset();
        wait_done(300, edges);
        check_eq("stall_ok", sysid_ok, 1);
        check_eq("stall_stable", stab_err, 0);
        check_eq("stall_cycles", stall_mon, NRD * 5);
        check_eq("stall_ts", ts_value, TSEN ? EXP_TS : 32'd0);
        stall_cycles = 0;

        // Slave accepts but never returns data
        respond = 1'b0;
        apply_reset();
        wait_done(1000, edges);
        check_eq("tmo_done", edges > 0, 1);
        check_eq("tmo_fail", sysid_fail, 1);
        check_eq("tmo_err", timeout_err, 1);
        check_eq("tmo_ok", sysid_ok, 0);
        check_eq("tmo_att", attempts, 4);
        check_eq("tmo_reads", acc_cnt, 4);
        check_eq("tmo_addr1", addr1_seen, 0);
        respond = 1'b1;

        // Reset while the last command is stalled, then recheck from PASS
        stall_cycles = 4;
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            #1;
            if (avm_read && avm_waitrequest && avm_address == LAST_ADDR) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("abort_found", found, 1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_read", avm_read, 0);
        check_eq("abort_busy", busy, 1);
        stall_cycles = 0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_done(200, edges);
        check_eq("rerun_latency", edges, LAT);
        check_eq("rerun_ok", sysid_ok, 1);
        recheck = 1'b1;
        @(negedge clock);
        recheck = 1'b0;
        check_eq("recheck_ok", sysid_ok, 0);
        check_eq("recheck_busy", busy, 1);
        check_eq("recheck_att", attempts, 0);
        wait_done(200, edges);
        check_eq("recheck_latency", edges, LAT);
        check_eq("recheck_pass", sysid_ok, 1);
        check_eq("recheck_att1", attempts, 1);
        check_eq("never_both", both_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
